// File: rtl/sample_capture_reader_pkg.sv
// Shared constants for the sample capture reader: register map, bit positions
// and default geometry.
package sample_capture_reader_pkg;

    localparam int unsigned DEFAULT_FIFO_DEPTH = 32;
    localparam int unsigned DEFAULT_SAMPLE_W   = 10;
    localparam int unsigned DECIM_W            = 16;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_DECIM  = 2'd1,
        REG_STATUS = 2'd2,
        REG_DATA   = 2'd3
    } reg_addr_e;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_CLR_BIT    = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 2;

    localparam int unsigned STAT_COUNT_LSB  = 0;
    localparam int unsigned STAT_COUNT_W    = 6;
    localparam int unsigned STAT_EMPTY_BIT  = 8;
    localparam int unsigned STAT_FULL_BIT   = 9;
    localparam int unsigned STAT_OVF_BIT    = 10;

    localparam int unsigned DATA_VALID_BIT  = 31;

endpackage

// File: rtl/sample_capture_reader_fifo.sv
// Sample FIFO: power-of-two storage with wrapping pointers, occupancy count,
// synchronous clear, and push accepted when full only alongside a pop.
module sample_fifo
    import sample_capture_reader_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned W     = DEFAULT_SAMPLE_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_capture_reader.sv
// Bus-slave capture block: decimates the sine sample stream into a FIFO that
// software drains through a small register map, with a half-full interrupt.
module sample_capture_reader
    import sample_capture_reader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned SAMPLE_W   = DEFAULT_SAMPLE_W
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                ChipSelect,
    input  logic                Write,
    input  logic                Read,
    input  logic [1:0]          Address,
    input  logic [31:0]         WriteData,
    output logic [31:0]         ReadData,
    input  logic [SAMPLE_W-1:0] iData_sin,
    output logic                oIrq
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    reg_addr_e            addr;
    logic                 wr_en;
    logic                 rd_en;
    logic                 ctrl_en;
    logic                 ctrl_irq_en;
    logic                 clr_pending;
    logic [DECIM_W-1:0]   decim_n;
    logic [DECIM_W-1:0]   decim_cnt;
    logic                 overflow;
    logic                 push;
    logic                 data_rd;
    logic                 pop_valid;
    logic                 ovf_set;
    logic [SAMPLE_W-1:0]  fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [31:0]          rd_mux;
    logic                 unused_wdata;

    assign addr      = reg_addr_e'(Address);
    assign wr_en     = ChipSelect && Write;
    assign rd_en     = ChipSelect && Read;
    assign push      = ctrl_en && (decim_cnt == decim_n);
    assign data_rd   = rd_en && (addr == REG_DATA);
    // A pending clear overrides both ends of the FIFO in its cycle.
    assign pop_valid = data_rd && !fifo_empty && !clr_pending;
    assign ovf_set   = push && fifo_full && !pop_valid && !clr_pending;
    assign unused_wdata = ^WriteData[31:DECIM_W];

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SAMPLE_W)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Reset),
        .clear (clr_pending),
        .push  (push),
        .pop   (data_rd && !clr_pending),
        .din   (iData_sin),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_CTRL: begin
                rd_mux[CTRL_EN_BIT]     = ctrl_en;
                rd_mux[CTRL_IRQ_EN_BIT] = ctrl_irq_en;
            end
            REG_DECIM: rd_mux[DECIM_W-1:0] = decim_n;
            REG_STATUS: begin
                rd_mux[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
                rd_mux[STAT_EMPTY_BIT] = fifo_empty;
                rd_mux[STAT_FULL_BIT]  = fifo_full;
                rd_mux[STAT_OVF_BIT]   = overflow;
            end
            REG_DATA: begin
                if (pop_valid) begin
                    rd_mux[SAMPLE_W-1:0]    = fifo_dout;
                    rd_mux[DATA_VALID_BIT]  = 1'b1;
                end
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            clr_pending <= 1'b0;
            decim_n     <= '0;
            decim_cnt   <= '0;
            overflow    <= 1'b0;
            ReadData    <= '0;
            oIrq        <= 1'b0;
        end else begin
            if (wr_en && addr == REG_CTRL) begin
                ctrl_en     <= WriteData[CTRL_EN_BIT];
                ctrl_irq_en <= WriteData[CTRL_IRQ_EN_BIT];
                clr_pending <= WriteData[CTRL_CLR_BIT];
            end else begin
                clr_pending <= 1'b0;
            end

            if (wr_en && addr == REG_DECIM) begin
                decim_n <= WriteData[DECIM_W-1:0];
            end

            if (clr_pending || (wr_en && addr == REG_DECIM) || !ctrl_en || push) begin
                decim_cnt <= '0;
            end else begin
                decim_cnt <= decim_cnt + 1'b1;
            end

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (wr_en && addr == REG_STATUS && WriteData[STAT_OVF_BIT]) begin
                overflow <= 1'b0;
            end

            if (rd_en) begin
                ReadData <= rd_mux;
            end

            oIrq <= ctrl_irq_en && (fifo_count >= CW'(FIFO_DEPTH / 2));
        end
    end

endmodule

// File: tb/tb_sample_capture_reader.sv
// Directed self-checking bench for sample_capture_reader (default geometry:
// 32-entry FIFO, 10-bit samples).
module tb_sample_capture_reader;

    logic        Clk;
    logic        Reset;
    logic        ChipSelect;
    logic        Write;
    logic        Read;
    logic [1:0]  Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [9:0]  iData_sin;
    logic        oIrq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rdata;

    sample_capture_reader #(
        .FIFO_DEPTH (32),
        .SAMPLE_W   (10)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ChipSelect (ChipSelect),
        .Write      (Write),
        .Read       (Read),
        .Address    (Address),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .iData_sin  (iData_sin),
        .oIrq       (oIrq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        ChipSelect = 1'b1; Write = 1'b1; Address = a; WriteData = d;
        cycle();
        ChipSelect = 1'b0; Write = 1'b0; WriteData = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        ChipSelect = 1'b1; Read = 1'b1; Address = a;
        cycle();
        ChipSelect = 1'b0; Read = 1'b0;
        d = ReadData;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        ChipSelect = 1'b0; Write = 1'b0; Read = 1'b0;
        Address = 2'd0; WriteData = '0; iData_sin = '0;
        Reset = 1'b1;
        cycle(); cycle();
        check("reset_readdata", ReadData, 32'h0);
        check("reset_irq", {31'd0, oIrq}, 32'h0);
        Reset = 1'b0;
        bus_read(2'd2, rdata); check("reset_status", rdata, 32'h0000_0100);
        bus_read(2'd0, rdata); check("reset_ctrl", rdata, 32'h0);

        // DECIM=3: one push every 4 enabled cycles.
        iData_sin = 10'd77;
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h1);
        cycle(); cycle(); cycle();
        bus_read(2'd2, rdata); check("decim3_t4", rdata, 32'h0000_0100);
        bus_read(2'd2, rdata); check("decim3_t5", rdata, 32'h0000_0001);
        for (int i = 0; i < 35; i++) cycle();
        bus_read(2'd2, rdata); check("decim3_t41", rdata, 32'h0000_000A);
        bus_write(2'd0, 32'h0);
        bus_write(2'd0, 32'h2);
        cycle();
        bus_read(2'd2, rdata); check("clear_status", rdata, 32'h0000_0100);
        bus_read(2'd0, rdata); check("clear_ctrl", rdata, 32'h0);

        // DECIM=0 ramp 0..39: fills at 32, remaining samples overflow.
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 39; i++) begin
            iData_sin = 10'(i);
            cycle();
        end
        iData_sin = 10'd39;
        bus_write(2'd0, 32'h0);
        bus_read(2'd2, rdata); check("ovf_status", rdata, 32'h0000_0620);
        check("ovf_irq_off", {31'd0, oIrq}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            bus_read(2'd3, rdata);
            check($sformatf("ramp_pop%0d", i), rdata, 32'h8000_0000 | 32'(i));
        end
        bus_read(2'd3, rdata); check("empty_pop", rdata, 32'h0);
        bus_read(2'd2, rdata); check("empty_status_ovf", rdata, 32'h0000_0500);
        bus_write(2'd2, 32'h0000_0400);
        bus_read(2'd2, rdata); check("w1c_status", rdata, 32'h0000_0100);

        // Full FIFO with simultaneous push and pop.
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'h1);
        for (int i = 1; i <= 65; i++) begin
            iData_sin = 10'(i);
            cycle();
        end
        iData_sin = 10'd66;
        bus_read(2'd3, rdata); check("full_pushpop", rdata, 32'h8000_0002);
        iData_sin = 10'd67;
        bus_write(2'd0, 32'h0);
        bus_read(2'd2, rdata); check("full_pushpop_status", rdata, 32'h0000_0220);
        for (int k = 0; k < 32; k++) begin
            bus_read(2'd3, rdata);
            check($sformatf("full_drain%0d", k), rdata, 32'h8000_0000 | 32'(4 + 2 * k));
        end
        bus_read(2'd2, rdata); check("drained_status", rdata, 32'h0000_0100);

        // Interrupt at half full.
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h5);
        for (int i = 1; i <= 15; i++) begin
            iData_sin = 10'(300 + i);
            cycle();
        end
        iData_sin = 10'd316;
        bus_write(2'd0, 32'h4);
        check("irq_lag", {31'd0, oIrq}, 32'h0);
        cycle();
        check("irq_rise", {31'd0, oIrq}, 32'h1);
        bus_read(2'd2, rdata); check("irq_status16", rdata, 32'h0000_0010);
        bus_read(2'd3, rdata); check("irq_pop", rdata, 32'h8000_012D);
        check("irq_still_high", {31'd0, oIrq}, 32'h1);
        cycle();
        check("irq_fall", {31'd0, oIrq}, 32'h0);

        // Reset while capturing with 20 samples buffered.
        bus_write(2'd0, 32'h5);
        for (int i = 1; i <= 5; i++) begin
            iData_sin = 10'(400 + i);
            cycle();
        end
        check("pre_reset_irq", {31'd0, oIrq}, 32'h1);
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        check("midreset_readdata", ReadData, 32'h0);
        check("midreset_irq", {31'd0, oIrq}, 32'h0);
        bus_read(2'd2, rdata); check("midreset_status", rdata, 32'h0000_0100);
        bus_read(2'd0, rdata); check("midreset_ctrl", rdata, 32'h0);

        // Write and read of the same register in one cycle.
        ChipSelect = 1'b1; Write = 1'b1; Read = 1'b1; Address = 2'd1; WriteData = 32'd5;
        cycle();
        ChipSelect = 1'b0; Write = 1'b0; Read = 1'b0;
        check("rw_same_cycle", ReadData, 32'h0);
        bus_read(2'd1, rdata); check("decim_readback", rdata, 32'h0000_0005);
        bus_write(2'd0, 32'h3);
        bus_read(2'd0, rdata); check("ctrl_clr_reads0", rdata, 32'h0000_0001);
        bus_write(2'd0, 32'h0);

        // Pop on empty with push, then clear winning over pop.
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h1);
        iData_sin = 10'd50;
        bus_read(2'd3, rdata); check("empty_pushpop", rdata, 32'h0);
        cycle();
        bus_read(2'd2, rdata); check("empty_pushpop_count", rdata, 32'h0000_0002);
        bus_write(2'd0, 32'h2);
        bus_read(2'd3, rdata); check("clear_wins_pop", rdata, 32'h0);
        bus_read(2'd2, rdata); check("clear_wins_status", rdata, 32'h0000_0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
